scan_sel_sequencer: RTL and testbench
=====================================

Name: scan_sel_sequencer

Overview:
- Sequential code generator feeding a 3-to-8 decoder; produces 3-bit select {sel_a, sel_b, sel_c}, sel_a = MSB.
- Steps the code at a prescaled rate to drive one-hot scanning (LED chaser, digit multiplexing, row scan).
- Supports wrap and ping-pong modes, direction control, synchronous load, and pulse outputs for end-of-scan.

Parameters:
- PRESCALE, 4, clocks per step (legal range 1..65535); PRESCALE=1 steps every enabled clock.
- PW, 16, prescaler counter width; must satisfy 2**PW >= PRESCALE.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  enables the prescaler and stepping; holds all state when low.
- dir  input  1  0 = count up, 1 = count down; used only in wrap mode.
- mode  input  1  0 = wrap, 1 = ping-pong.
- load  input  1  synchronous load strobe.
- load_val  input  3  code loaded when load=1.
- sel_a  output  1  code bit 2 (MSB), registered.
- sel_b  output  1  code bit 1, registered.
- sel_c  output  1  code bit 0 (LSB), registered.
- step  output  1  one-cycle pulse in the cycle the code changes due to a tick.
- wrap_pulse  output  1  one-cycle pulse on a scan boundary (see below).

Behaviour:
- Reset (async, rst_n=0): code=0, prescaler=0, pp_dir=up, step=0, wrap_pulse=0. Outputs are valid at 0 immediately.
- Prescaler: when en=1, counts 0..PRESCALE-1; tick = en && (prescaler == PRESCALE-1); the prescaler returns to 0 on tick. When en=0, the prescaler holds.
- Code update occurs on the clock edge at which tick=1. The new code is visible on sel_* in the next cycle, with step=1 in that same cycle.
- Wrap mode, up: 0,1,...,7,0,... The 7->0 transition sets wrap_pulse=1 together with step.
- Wrap mode, down: 7,6,...,0,7,... The 0->7 transition sets wrap_pulse=1.
- In wrap mode, pp_dir tracks dir every cycle. A change of dir takes effect on the next tick.
- Ping-pong mode ignores dir. Sequence from 0 going up: 0..7,6..0,1...
  - At 7 while going up: the next step goes to 6 and pp_dir becomes down.
  - At 0 while going down: the next step goes to 1 and pp_dir becomes up.
  - wrap_pulse asserts with the step that leaves an endpoint, i.e. the 7->6 and 0->1 transitions.
- Entering ping-pong: the initial pp_dir is the last dir value seen in wrap mode. If the code is at an endpoint, the reversal rule applies on the first tick.
- Load has priority over tick. When load=1 (en irrelevant):
  - code=load_val and prescaler=0;
  - step=0 and wrap_pulse=0 in the following cycle.
  - The next tick occurs PRESCALE enabled cycles later.
  - pp_dir is unchanged.
- Pulse behaviour: step and wrap_pulse are each high for exactly one cycle per tick and low otherwise. wrap_pulse never asserts without step.
- en deasserted mid-count: prescaler and code freeze. Resuming continues from the frozen prescaler value; the count is not restarted.
- Reset mid-operation: all state returns to reset values immediately. The first tick after rst_n release occurs PRESCALE enabled cycles later.
- All arithmetic on the code is modulo 8 (3-bit). The prescaler compares against PRESCALE-1 truncated to PW bits.

Decomposition:
- Shared package/header: MODE_WRAP=0, MODE_PP=1, DIR_UP=0, DIR_DOWN=1, CODE_MAX=3'd7.
- One natural sub-module: scan_prescaler (parameterised PRESCALE/PW; inputs clk, rst_n, en, clr; output tick).
- Next-code/direction logic and the output registers stay in scan_sel_sequencer.
- The top-level integration connects sel_a/sel_b/sel_c directly to the decoder's a/b/c inputs.

Test Plan:
- Reset, then en=1, mode=0, dir=0, PRESCALE=4 -> code 0,1,2,...,7,0 changing every 4 clocks; step pulses every 4 clocks; wrap_pulse only on the 7->0 step.
- mode=0, dir=1 from reset -> 0->7 on the first tick with wrap_pulse=1, then 6,5,...
- mode=1 from code 0 -> 0..7,6,...,0,1 with wrap_pulse on the 7->6 and 0->1 steps only; toggling dir has no effect.
- load=1 with load_val=5 while tick would fire -> code=5, no step that cycle, next step to 6 after exactly 4 enabled clocks.
- en dropped for 10 clocks after 2 prescaler counts -> code frozen; after re-enable, the next step occurs 2 clocks later.
- rst_n pulsed low asynchronously mid-count at code=6 -> outputs go to 0 before the next clock edge; stepping resumes from 0 after 4 clocks. Repeat with PRESCALE=1: the code advances every enabled clock.

Source files
------------

// File: rtl/scan_sel_sequencer_pkg.sv
// Shared encodings for the scan select sequencer: mode, direction and code limits.
package scan_sel_sequencer_pkg;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_PP   = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic [2:0] CODE_MAX = 3'd7;
endpackage

// File: rtl/scan_prescaler.sv
// Free-running step prescaler: tick fires on the PRESCALE-th enabled clock, then restarts.
// clr zeroes the count regardless of en; en low freezes the count.
module scan_prescaler #(
  parameter int PRESCALE = 4,
  parameter int PW       = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/scan_sel_sequencer.sv
// 3-bit select code generator for a 3-to-8 decoder, stepping in wrap or ping-pong order.
// sel_* change one cycle after a tick; step/wrap_pulse are one-cycle pulses aligned with the new code.
module scan_sel_sequencer
  import scan_sel_sequencer_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int PW       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dir,
  input  logic       mode,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       sel_a,
  output logic       sel_b,
  output logic       sel_c,
  output logic       step,
  output logic       wrap_pulse
);
  logic       tick;
  logic [2:0] code, code_nxt;
  logic       pp_dir, pp_dir_nxt;
  logic       step_nxt, wrap_nxt;

  scan_prescaler #(.PRESCALE(PRESCALE), .PW(PW)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (load),
    .tick  (tick)
  );

  always_comb begin
    code_nxt   = code;
    pp_dir_nxt = pp_dir;
    step_nxt   = 1'b0;
    wrap_nxt   = 1'b0;
    if (load) begin
      code_nxt = load_val;
    end else begin
      // In wrap mode pp_dir shadows dir so ping-pong starts in the last wrap direction.
      if (mode == MODE_WRAP) begin
        pp_dir_nxt = dir;
      end
      if (tick) begin
        step_nxt = 1'b1;
        if (mode == MODE_WRAP) begin
          if (dir == DIR_UP) begin
            code_nxt = code + 3'd1;
            wrap_nxt = (code == CODE_MAX);
          end else begin
            code_nxt = code - 3'd1;
            wrap_nxt = (code == 3'd0);
          end
        end else begin
          // Leaving either endpoint counts as a scan boundary, whatever the approach direction.
          wrap_nxt = (code == CODE_MAX) || (code == 3'd0);
          if (code == CODE_MAX) begin
            code_nxt   = CODE_MAX - 3'd1;
            pp_dir_nxt = DIR_DOWN;
          end else if (code == 3'd0) begin
            code_nxt   = 3'd1;
            pp_dir_nxt = DIR_UP;
          end else if (pp_dir == DIR_UP) begin
            code_nxt = code + 3'd1;
          end else begin
            code_nxt = code - 3'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code       <= 3'd0;
      pp_dir     <= DIR_UP;
      step       <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      code       <= code_nxt;
      pp_dir     <= pp_dir_nxt;
      step       <= step_nxt;
      wrap_pulse <= wrap_nxt;
    end
  end

  assign {sel_a, sel_b, sel_c} = code;
endmodule

// File: tb/tb_scan_sel_sequencer.sv
// Directed bench: a ping-pong phase model checked every cycle, plus literal checkpoints.
module tb_scan_sel_sequencer;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, dir = 1'b0, mode = 1'b0, load = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic       sel_a, sel_b, sel_c, step, wrap_pulse;

  logic       rst1_n = 1'b0;
  logic       en1 = 1'b1;
  logic       zero_b = 1'b0;
  logic [2:0] zero3 = 3'd0;
  logic       s1a, s1b, s1c, step1, wrap1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  scan_sel_sequencer #(.PRESCALE(P), .PW(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c),
    .step(step), .wrap_pulse(wrap_pulse)
  );

  scan_sel_sequencer #(.PRESCALE(1), .PW(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .en(en1), .dir(zero_b), .mode(zero_b), .load(zero_b),
    .load_val(zero3), .sel_a(s1a), .sel_b(s1b), .sel_c(s1c),
    .step(step1), .wrap_pulse(wrap1)
  );

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: elapsed enabled cycles since last restart; ping-pong as a phase on a 14-step ring.
  int m_code = 0, m_ppdir = 0, m_el = 0;
  int m_step = 0, m_wrap = 0;

  always @(negedge rst_n) begin
    m_code = 0; m_ppdir = 0; m_el = 0; m_step = 0; m_wrap = 0;
  end

  always @(posedge clk) begin : model
    int ph;
    bit tk;
    if (rst_n === 1'b1) begin
      m_step = 0;
      m_wrap = 0;
      if (load) begin
        m_code = int'(load_val);
        m_el = 0;
      end else begin
        tk = 0;
        if (en) begin
          m_el++;
          if (m_el == P) begin tk = 1; m_el = 0; end
        end
        if (tk && !mode) begin
          m_wrap = dir ? int'(m_code == 0) : int'(m_code == 7);
          m_code = (m_code + (dir ? 7 : 1)) % 8;
          m_step = 1;
        end else if (tk) begin
          ph = m_ppdir ? (14 - m_code) % 14 : m_code;
          m_wrap = int'(ph == 0 || ph == 7);
          ph = (ph + 1) % 14;
          m_code = (ph <= 7) ? ph : 14 - ph;
          m_ppdir = int'(ph == 0 || ph >= 8);
          m_step = 1;
        end
        if (!mode) m_ppdir = int'(dir);
      end
    end
  end

  always @(negedge clk) begin
    chk("cycle_code", {5'd0, sel_a, sel_b, sel_c}, 8'(m_code));
    chk("cycle_step", {7'd0, step}, 8'(m_step));
    chk("cycle_wrap", {7'd0, wrap_pulse}, 8'(m_wrap));
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic toggle_run(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      dir = ~dir;
    end
  endtask

  task automatic lit(input string name, input int c, input int s, input int w);
    chk({name, "_code"}, {5'd0, sel_a, sel_b, sel_c}, 8'(c));
    chk({name, "_step"}, {7'd0, step}, 8'(s));
    chk({name, "_wrap"}, {7'd0, wrap_pulse}, 8'(w));
  endtask

  initial begin
    #1;
    lit("reset", 0, 0, 0);
    cycles(2);
    // Wrap up
    rst_n = 1'b1; en = 1'b1;
    cycles(4);  lit("up_first", 1, 1, 0);
    cycles(1);  lit("up_gap", 1, 0, 0);
    cycles(23); lit("up_seven", 7, 1, 0);
    cycles(4);  lit("up_wrap", 0, 1, 1);
    // Wrap down from reset
    rst_n = 1'b0; dir = 1'b1;
    cycles(1); rst_n = 1'b1;
    cycles(4); lit("dn_wrap", 7, 1, 1);
    cycles(4); lit("dn_next", 6, 1, 0);
    // Ping-pong from 0, dir toggling throughout
    rst_n = 1'b0; dir = 1'b0; mode = 1'b1;
    cycles(1); rst_n = 1'b1;
    toggle_run(4);  lit("pp_leave0", 1, 1, 1);
    toggle_run(24); lit("pp_seven", 7, 1, 0);
    toggle_run(4);  lit("pp_leave7", 6, 1, 1);
    toggle_run(24); lit("pp_zero", 0, 1, 0);
    toggle_run(4);  lit("pp_bounce", 1, 1, 1);
    // Load exactly when tick would fire
    rst_n = 1'b0; dir = 1'b0; mode = 1'b0;
    cycles(1); rst_n = 1'b1;
    cycles(3); load = 1'b1; load_val = 3'd5;
    cycles(1); load = 1'b0; lit("load", 5, 0, 0);
    cycles(3); lit("load_hold", 5, 0, 0);
    cycles(1); lit("load_step", 6, 1, 0);
    // en dropped after two prescaler counts
    cycles(2); en = 1'b0;
    cycles(10); lit("freeze", 6, 0, 0);
    en = 1'b1;
    cycles(1); lit("resume1", 6, 0, 0);
    cycles(1); lit("resume2", 7, 1, 0);
    // Async reset mid-count at code 6
    load = 1'b1; load_val = 3'd6;
    cycles(1); load = 1'b0;
    cycles(2);
    #1 rst_n = 1'b0;
    #1 lit("async_rst", 0, 0, 0);
    cycles(1); rst_n = 1'b1;
    cycles(3); lit("post_rst_hold", 0, 0, 0);
    cycles(1); lit("post_rst_step", 1, 1, 0);
    // PRESCALE=1 instance
    chk("p1_reset", {5'd0, s1a, s1b, s1c}, 8'd0);
    rst1_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycles(1);
      chk("p1_code", {5'd0, s1a, s1b, s1c}, 8'(k % 8));
      chk("p1_step", {7'd0, step1}, 8'd1);
      chk("p1_wrap", {7'd0, wrap1}, (k % 8 == 0) ? 8'd1 : 8'd0);
    end
    #1 rst1_n = 1'b0;
    #1 chk("p1_async_rst", {5'd0, s1a, s1b, s1c}, 8'd0);
    cycles(1); rst1_n = 1'b1;
    cycles(1); chk("p1_restart", {5'd0, s1a, s1b, s1c}, 8'd1);
    cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
